// File: rtl/cv32e40p_pkg.sv
// Shared types for the instruction fetch path.
//   fetch_entry_t : one buffered fetch result {addr, data, err}
package cv32e40p_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/cv32e40p_fetch_fifo.sv
// Synchronous FIFO with registered storage and a synchronous flush.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears storage too)
//   flush_i   : empties the FIFO; overrides push/pop in the same cycle
//   push_i    : write wdata_i (caller guarantees not full)
//   pop_i     : drop the head (caller guarantees not empty)
//   rdata_o   : head entry, straight from the storage registers
//   cnt_o     : number of valid entries
import cv32e40p_pkg::*;

module cv32e40p_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [PW-1:0]               r_wptr;
    logic [PW-1:0]               r_rptr;
    logic [CW-1:0]               r_cnt;
    logic [PW-1:0]               w_wptr_inc;
    logic [PW-1:0]               w_rptr_inc;

    // Explicit wrap so DEPTH need not be a power of two.
    assign w_wptr_inc = (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
    assign w_rptr_inc = (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);

    assign rdata_o = r_mem[r_rptr];
    assign cnt_o   = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (push_i) begin
                r_mem[r_wptr] <= wdata_i;
                r_wptr        <= w_wptr_inc;
            end
            if (pop_i) begin
                r_rptr <= w_rptr_inc;
            end
            r_cnt <= r_cnt + CW'(push_i) - CW'(pop_i);
        end
    end

endmodule

// File: rtl/cv32e40p_prefetch_buffer.sv
// Instruction prefetch buffer between IF and an OBI-style instruction port.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   boot_addr_i                   : fetch start address while in reset
//   req_i                         : fetch enable from IF
//   branch_i, branch_addr_i       : flush and redirect
//   fetch_valid_o/rdata_o/addr_o/err_o, fetch_ready_i : FIFO head to IF
//   instr_req_o/addr_o, instr_gnt_i                   : OBI address phase
//   instr_rvalid_i/rdata_i/err_i                      : OBI response phase
//   busy_o                        : request pending or responses outstanding
import cv32e40p_pkg::*;

module cv32e40p_prefetch_buffer #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] boot_addr_i,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic [31:0] fetch_addr_o,
    output logic        fetch_err_o,
    input  logic        fetch_ready_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(DEPTH + 1);

    logic         r_req;
    logic [31:0]  r_addr;
    logic [31:0]  r_faddr;     // address of the next request to issue
    logic [OW-1:0] r_disc;
    logic         r_stale;     // pending request was issued before a branch

    logic [OW-1:0] w_outs;     // outstanding = occupancy of the address queue
    logic [OW-1:0] w_outs_nxt;
    logic [OW-1:0] w_disc_nxt;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_gnt;
    logic          w_rv;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic [31:0]   w_faddr_cur;
    logic [31:0]   w_br_addr;
    logic [31:0]   w_boot_addr;
    logic [31:0]   w_rsp_addr;
    fetch_entry_t  w_wentry;
    fetch_entry_t  w_head;

    assign w_br_addr   = branch_addr_i & 32'hFFFF_FFFC;
    assign w_boot_addr = boot_addr_i   & 32'hFFFF_FFFC;

    assign w_gnt  = r_req & instr_gnt_i;
    // A response with nothing outstanding (e.g. left over from before reset) is ignored.
    assign w_rv   = instr_rvalid_i & (w_outs != '0);
    assign w_push = w_rv & (r_disc == '0) & ~branch_i;
    assign w_pop  = fetch_valid_o & fetch_ready_i & ~branch_i;

    assign w_outs_nxt = w_outs + OW'(w_gnt) - OW'(w_rv);
    assign w_cnt_nxt  = branch_i ? '0 : (w_cnt + CW'(w_push) - CW'(w_pop));

    // On branch, everything still outstanding after this cycle is stale. A request
    // still waiting for grant is marked stale and joins disc when it is granted.
    always_comb begin
        w_disc_nxt = r_disc;
        if (branch_i) begin
            w_disc_nxt = w_outs_nxt;
        end else begin
            w_disc_nxt = r_disc - OW'(w_rv & (r_disc != '0)) + OW'(w_gnt & r_stale);
        end
    end

    assign w_faddr_cur = branch_i ? w_br_addr : r_faddr;

    // Reserve a FIFO slot for every issued request so responses never need back-pressure.
    // Evaluated on next-state counts so back-to-back issue keeps 1 word/cycle.
    assign w_issue = req_i & (~r_req | w_gnt)
                   & (int'(w_outs_nxt) < MAX_OUTSTANDING)
                   & (int'(w_cnt_nxt) + int'(w_outs_nxt) < DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req   <= 1'b0;
            r_addr  <= w_boot_addr;
            r_faddr <= w_boot_addr;
            r_disc  <= '0;
            r_stale <= 1'b0;
        end else begin
            r_disc  <= w_disc_nxt;
            r_stale <= r_req & ~w_gnt & (r_stale | branch_i);
            if (w_issue) begin
                r_req   <= 1'b1;
                r_addr  <= w_faddr_cur;
                r_faddr <= w_faddr_cur + 32'd4;
            end else begin
                if (w_gnt) begin
                    r_req <= 1'b0;
                end
                r_faddr <= w_faddr_cur;
            end
        end
    end

    cv32e40p_fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_addr_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (1'b0),
        .push_i  (w_gnt),
        .wdata_i (r_addr),
        .pop_i   (w_rv),
        .rdata_o (w_rsp_addr),
        .cnt_o   (w_outs)
    );

    assign w_wentry.addr = w_rsp_addr;
    assign w_wentry.data = instr_rdata_i;
    assign w_wentry.err  = instr_err_i;

    cv32e40p_fetch_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (branch_i),
        .push_i  (w_push),
        .wdata_i (w_wentry),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .cnt_o   (w_cnt)
    );

    assign fetch_valid_o = (w_cnt != '0);
    assign fetch_rdata_o = w_head.data;
    assign fetch_addr_o  = w_head.addr;
    assign fetch_err_o   = w_head.err;
    assign instr_req_o   = r_req;
    assign instr_addr_o  = r_addr;
    assign busy_o        = r_req | (w_outs != '0);

endmodule

// File: tb/tb_cv32e40p_prefetch_buffer.sv
module tb_cv32e40p_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] boot_addr_i = 32'h0000_0080;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = 32'h0;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_err_o;
    logic        fetch_ready_i = 1'b1;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = 32'h0;
    logic        instr_err_i = 1'b0;
    logic        busy_o;

    cv32e40p_prefetch_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst), .boot_addr_i(boot_addr_i), .req_i(req_i),
        .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .fetch_valid_o(fetch_valid_o), .fetch_rdata_o(fetch_rdata_o),
        .fetch_addr_o(fetch_addr_o), .fetch_err_o(fetch_err_o),
        .fetch_ready_i(fetch_ready_i), .instr_req_o(instr_req_o),
        .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .instr_err_i(instr_err_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Memory model: in-order queue of granted addresses; data = ~addr.
    logic [31:0] mq[$];
    bit          gnt_en = 1'b0;
    bit          rv_en = 1'b1;
    logic [31:0] err_addr = 32'h0000_0001;
    bit          chk_stream = 1'b0;
    logic [31:0] exp_next = 32'h0;
    int          pops = 0;

    typedef struct {
        logic        rst, req, rdy, gen;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] efa;
        logic        ebusy;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(logic r, logic q, logic rd, logic g, logic er,
                                logic [31:0] ea, logic ev, logic [31:0] ef, logic eb);
        vec_t v;
        v.rst = r; v.req = q; v.rdy = rd; v.gen = g; v.ereq = er;
        v.eaddr = ea; v.evld = ev; v.efa = ef; v.ebusy = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // One clock: drive memory side, check stream pops, advance, settle.
    task automatic cyc();
        logic [31:0] a;
        logic [31:0] ga;
        logic        g;
        g  = instr_req_o & gnt_en;
        ga = instr_addr_o;
        instr_gnt_i    = g;
        instr_rvalid_i = rv_en && (mq.size() != 0);
        a = (mq.size() != 0) ? mq[0] : 32'h0;
        instr_rdata_i = ~a;
        instr_err_i   = instr_rvalid_i && (a == err_addr);
        #1;
        if (chk_stream) begin
            if (branch_i) begin
                exp_next = branch_addr_i & 32'hFFFF_FFFC;
            end else if (fetch_valid_o && fetch_ready_i) begin
                chk("stream addr", fetch_addr_o, exp_next);
                chk("stream data", fetch_rdata_o, ~exp_next);
                exp_next = exp_next + 32'd4;
                pops++;
            end
        end
        @(posedge clk);
        if (instr_rvalid_i) void'(mq.pop_front());
        if (g) mq.push_back(ga);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_i = 1'b0; branch_i = 1'b0;
        gnt_en = 1'b0; rv_en = 1'b0; fetch_ready_i = 1'b1;
        cyc(); cyc();
        mq.delete();
        rst = 1'b0; rv_en = 1'b1;
    endtask

    task automatic wait_valid(input string nm);
        int k;
        k = 0;
        while (!fetch_valid_o && k < 20) begin
            cyc();
            k++;
        end
        chk1({nm, " valid"}, fetch_valid_o, 1'b1);
    endtask

    initial begin
        // rst, req, rdy, gnt_en | exp req, addr, valid, fetch_addr, busy
        tv.push_back(mk(1,1,1,1, 0,32'h80,0,32'h0 ,0));
        tv.push_back(mk(1,1,1,1, 0,32'h80,0,32'h0 ,0));
        // boot, zero-wait memory, one pop per cycle
        tv.push_back(mk(0,1,1,1, 1,32'h80,0,32'h0 ,1));
        tv.push_back(mk(0,1,1,1, 1,32'h84,0,32'h0 ,1));
        tv.push_back(mk(0,1,1,1, 1,32'h88,1,32'h80,1));
        tv.push_back(mk(0,1,1,1, 1,32'h8C,1,32'h84,1));
        tv.push_back(mk(0,1,1,1, 1,32'h90,1,32'h88,1));
        // mid-run reset; the response landing after it must be ignored
        tv.push_back(mk(1,1,1,1, 0,32'h80,0,32'h0 ,0));
        // back-pressure: four grants then stop, resume at 0x90
        tv.push_back(mk(0,1,0,1, 1,32'h80,0,32'h0 ,1));
        tv.push_back(mk(0,1,0,1, 1,32'h84,0,32'h0 ,1));
        tv.push_back(mk(0,1,0,1, 1,32'h88,1,32'h80,1));
        tv.push_back(mk(0,1,0,1, 1,32'h8C,1,32'h80,1));
        tv.push_back(mk(0,1,0,1, 0,32'h8C,1,32'h80,1));
        tv.push_back(mk(0,1,0,1, 0,32'h8C,1,32'h80,0));
        tv.push_back(mk(0,1,0,1, 0,32'h8C,1,32'h80,0));
        tv.push_back(mk(0,1,1,1, 1,32'h90,1,32'h84,1));
        tv.push_back(mk(0,1,1,1, 1,32'h94,1,32'h88,1));

        foreach (tv[i]) begin
            rst = tv[i].rst; req_i = tv[i].req;
            fetch_ready_i = tv[i].rdy; gnt_en = tv[i].gen;
            cyc();
            chk1($sformatf("v%0d req", i), instr_req_o, tv[i].ereq);
            chk($sformatf("v%0d iaddr", i), instr_addr_o, tv[i].eaddr);
            chk1($sformatf("v%0d valid", i), fetch_valid_o, tv[i].evld);
            chk($sformatf("v%0d faddr", i), fetch_addr_o, tv[i].efa);
            chk1($sformatf("v%0d busy", i), busy_o, tv[i].ebusy);
            chk1($sformatf("v%0d err", i), fetch_err_o, 1'b0);
            if (tv[i].rst)
                chk($sformatf("v%0d rdata", i), fetch_rdata_o, 32'h0);
            else if (tv[i].evld)
                chk($sformatf("v%0d rdata", i), fetch_rdata_o, ~tv[i].efa);
        end

        // Branch with two requests in flight: both responses dropped.
        do_reset();
        req_i = 1'b1; gnt_en = 1'b1; rv_en = 1'b0;
        cyc(); cyc(); cyc();
        chk1("b2 req at limit", instr_req_o, 1'b0);
        chk1("b2 busy", busy_o, 1'b1);
        branch_i = 1'b1; branch_addr_i = 32'h0000_1002;
        cyc();
        branch_i = 1'b0; rv_en = 1'b1;
        cyc();
        chk1("b2 req after", instr_req_o, 1'b1);
        chk("b2 iaddr after", instr_addr_o, 32'h0000_1000);
        wait_valid("b2");
        chk("b2 head addr", fetch_addr_o, 32'h0000_1000);
        chk("b2 head data", fetch_rdata_o, ~32'h0000_1000);

        // Ungranted request across a branch: address held, response dropped.
        do_reset();
        req_i = 1'b1; gnt_en = 1'b0;
        cyc();
        branch_i = 1'b1; branch_addr_i = 32'h0000_1000;
        cyc();
        branch_i = 1'b0;
        chk1("ug req held", instr_req_o, 1'b1);
        chk("ug iaddr held", instr_addr_o, 32'h0000_0080);
        cyc();
        chk("ug iaddr held2", instr_addr_o, 32'h0000_0080);
        gnt_en = 1'b1;
        cyc();
        chk("ug next iaddr", instr_addr_o, 32'h0000_1000);
        wait_valid("ug");
        chk("ug head addr", fetch_addr_o, 32'h0000_1000);

        // Branch from idle, error response and address wrap; exact latencies.
        do_reset();
        gnt_en = 1'b1; err_addr = 32'hFFFF_FFFC;
        cyc();
        chk1("wr idle busy", busy_o, 1'b0);
        req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFFE;
        cyc();
        branch_i = 1'b0;
        chk1("wr req N+1", instr_req_o, 1'b1);
        chk("wr iaddr N+1", instr_addr_o, 32'hFFFF_FFFC);
        cyc();
        chk("wr iaddr wrap", instr_addr_o, 32'h0000_0000);
        chk1("wr no bypass", fetch_valid_o, 1'b0);
        cyc();
        chk1("wr valid N+3", fetch_valid_o, 1'b1);
        chk("wr head addr", fetch_addr_o, 32'hFFFF_FFFC);
        chk1("wr head err", fetch_err_o, 1'b1);
        cyc();
        chk("wr next addr", fetch_addr_o, 32'h0000_0000);
        chk1("wr next err", fetch_err_o, 1'b0);
        err_addr = 32'h0000_0001;

        // Random delays, back-pressure and branches against an in-order model.
        do_reset();
        exp_next = 32'h0000_0080;
        chk_stream = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            gnt_en        = ($urandom_range(0, 3) != 0);
            rv_en         = ($urandom_range(0, 2) != 0);
            fetch_ready_i = ($urandom_range(0, 3) != 0);
            req_i         = ($urandom_range(0, 15) != 0);
            branch_i      = ($urandom_range(0, 60) == 0);
            branch_addr_i = $urandom & 32'h0000_FFFF;
            cyc();
        end
        chk_stream = 1'b0;
        branch_i = 1'b0;
        chk1("stream progress", pops > 500, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
